// File: rtl/adat_in_stream.sv
// ADAT receiver capture stage: edge-detects each decoded frame, double-buffers it
// (shadow + stream buffer) and streams the channels one word per valid/ready beat.
module adat_in_stream #(
  parameter int NUM_CH         = 8,
  parameter int WIDTH          = 24,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int LOCK_FRAMES    = 2
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              in_valid,
  input  logic                              in_ready,
  input  logic [2:0]                        in_user,
  input  logic [NUM_CH-1:0][WIDTH-1:0]      in_audio,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic signed [WIDTH-1:0]           out_data,
  output logic [$clog2(NUM_CH)-1:0]         out_chan,
  output logic                              out_first,
  output logic                              out_last,
  output logic [2:0]                        out_user,
  output logic                              locked,
  output logic [7:0]                        overrun_count,
  output logic [7:0]                        bad_count
);

  localparam int CH_W  = $clog2(NUM_CH);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CV_W  = $clog2(LOCK_FRAMES + 1);

  localparam logic [CH_W-1:0]  LAST_CH = CH_W'(NUM_CH - 1);
  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);
  localparam logic [CV_W-1:0]  CV_MAX  = CV_W'(LOCK_FRAMES);

  typedef enum logic {
    S_IDLE,
    S_STREAM
  } state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [CV_W-1:0] sat_inc_cv(input logic [CV_W-1:0] v);
    return (v >= CV_MAX) ? CV_MAX : v + CV_W'(1);
  endfunction

  function automatic logic [TMO_W-1:0] sat_inc_tmo(input logic [TMO_W-1:0] v);
    return (v >= TMO_MAX) ? TMO_MAX : v + TMO_W'(1);
  endfunction

  // Control state
  logic                 rdy_q;
  state_t               state_q, state_d;
  logic [CH_W-1:0]      ch_q, ch_d;
  logic                 shadow_full_q, shadow_full_d;
  logic [CV_W-1:0]      cv_q, cv_d;
  logic [TMO_W-1:0]     tmo_q, tmo_d;
  logic                 locked_q, locked_d;
  logic [7:0]           overrun_q, overrun_d;
  logic [7:0]           bad_q, bad_d;

  // Data storage (not reset; always qualified by control state)
  logic [NUM_CH-1:0][WIDTH-1:0] sh_audio_q, sh_audio_d;
  logic [2:0]                   sh_user_q, sh_user_d;
  logic [NUM_CH-1:0][WIDTH-1:0] buf_q, buf_d;
  logic [2:0]                   buf_user_q, buf_user_d;

  logic cap;
  logic cap_valid;
  logic cap_bad;
  logic xfer;
  logic shadow_free;
  logic load;

  // Capture-event detection: rdy_q resets high so a level held through reset is ignored
  always_comb begin
    cap       = in_ready & ~rdy_q;
    cap_valid = cap & in_valid;
    cap_bad   = cap & ~in_valid;
  end

  // Stream FSM: IDLE waits for a full shadow, STREAM walks ch 0..NUM_CH-1
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    xfer    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (shadow_full_q) begin
          xfer    = 1'b1;
          ch_d    = '0;
          state_d = S_STREAM;
        end
      end
      S_STREAM: begin
        if (out_ready) begin
          if (ch_q != LAST_CH) begin
            ch_d = ch_q + CH_W'(1);
          end else if (shadow_full_q) begin
            xfer = 1'b1;
            ch_d = '0;
          end else begin
            ch_d    = '0;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        ch_d    = '0;
      end
    endcase
  end

  // A shadow emptied by this cycle's transfer can accept this cycle's capture
  always_comb begin
    shadow_free   = ~shadow_full_q | xfer;
    load          = cap_valid & shadow_free;
    shadow_full_d = shadow_full_q;
    if (load) begin
      shadow_full_d = 1'b1;
    end else if (xfer) begin
      shadow_full_d = 1'b0;
    end
    overrun_d = overrun_q;
    if (cap_valid && !shadow_free) begin
      overrun_d = sat_inc8(overrun_q);
    end
    bad_d = bad_q;
    if (cap_bad) begin
      bad_d = sat_inc8(bad_q);
    end
  end

  always_comb begin
    sh_audio_d = sh_audio_q;
    sh_user_d  = sh_user_q;
    buf_d      = buf_q;
    buf_user_d = buf_user_q;
    if (load) begin
      sh_audio_d = in_audio;
      sh_user_d  = in_user;
    end
    if (xfer) begin
      buf_d      = sh_audio_q;
      buf_user_d = sh_user_q;
    end
  end

  // Lock tracking: consecutive-valid counter plus a saturating silence timeout
  always_comb begin
    cv_d     = cv_q;
    tmo_d    = tmo_q;
    locked_d = locked_q;
    if (cap_valid) begin
      cv_d  = sat_inc_cv(cv_q);
      tmo_d = '0;
      if (cv_d == CV_MAX) begin
        locked_d = 1'b1;
      end
    end else begin
      tmo_d = sat_inc_tmo(tmo_q);
      if (tmo_d == TMO_MAX) begin
        cv_d     = '0;
        locked_d = 1'b0;
      end
      if (cap_bad) begin
        cv_d     = '0;
        locked_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_q         <= 1'b1;
      state_q       <= S_IDLE;
      ch_q          <= '0;
      shadow_full_q <= 1'b0;
      cv_q          <= '0;
      tmo_q         <= '0;
      locked_q      <= 1'b0;
      overrun_q     <= '0;
      bad_q         <= '0;
    end else begin
      rdy_q         <= in_ready;
      state_q       <= state_d;
      ch_q          <= ch_d;
      shadow_full_q <= shadow_full_d;
      cv_q          <= cv_d;
      tmo_q         <= tmo_d;
      locked_q      <= locked_d;
      overrun_q     <= overrun_d;
      bad_q         <= bad_d;
    end
  end

  always_ff @(posedge clk) begin
    sh_audio_q <= sh_audio_d;
    sh_user_q  <= sh_user_d;
    buf_q      <= buf_d;
    buf_user_q <= buf_user_d;
  end

  // Outputs are gated by state so reset forces them to zero without resetting data
  always_comb begin
    out_valid     = (state_q == S_STREAM);
    out_data      = out_valid ? $signed(buf_q[ch_q]) : '0;
    out_chan      = out_valid ? ch_q : '0;
    out_first     = out_valid && (ch_q == '0);
    out_last      = out_valid && (ch_q == LAST_CH);
    out_user      = out_valid ? buf_user_q : 3'b000;
    locked        = locked_q;
    overrun_count = overrun_q;
    bad_count     = bad_q;
  end

endmodule

// File: tb/tb_adat_in_stream.sv
// Directed bench for adat_in_stream: streaming, back-pressure, lock/timeout,
// invalid frames, same-cycle transfer/capture and mid-stream reset.
module tb_adat_in_stream;

  localparam int NUM_CH = 8;
  localparam int WIDTH  = 24;

  logic                         clk;
  logic                         rst;
  logic                         in_valid;
  logic                         in_ready;
  logic [2:0]                   in_user;
  logic [NUM_CH-1:0][WIDTH-1:0] in_audio;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [WIDTH-1:0]      out_data;
  logic [2:0]                   out_chan;
  logic                         out_first;
  logic                         out_last;
  logic [2:0]                   out_user;
  logic                         locked;
  logic [7:0]                   overrun_count;
  logic [7:0]                   bad_count;

  int n_checks = 0;
  int n_fail   = 0;

  adat_in_stream #(
    .NUM_CH(NUM_CH),
    .WIDTH(WIDTH),
    .TIMEOUT_CYCLES(4096),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_user(in_user),
    .in_audio(in_audio),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_chan(out_chan),
    .out_first(out_first),
    .out_last(out_last),
    .out_user(out_user),
    .locked(locked),
    .overrun_count(overrun_count),
    .bad_count(bad_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, act, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame_start(input logic vld, input logic [23:0] base, input logic [2:0] user);
    for (int i = 0; i < NUM_CH; i++) in_audio[i] = 24'(base + 24'(i));
    in_user  = user;
    in_valid = vld;
    in_ready = 1'b1;
  endtask

  task automatic frame_end();
    in_ready = 1'b0;
  endtask

  task automatic check_beat(input string tag, input int ch, input logic [23:0] data,
                            input logic [2:0] user);
    check_eq({tag, "_valid"}, 32'(out_valid), 32'd1);
    check_eq({tag, "_chan"},  32'(out_chan), 32'(ch));
    check_eq({tag, "_data"},  32'(unsigned'(out_data)), 32'(data));
    check_eq({tag, "_first"}, 32'(out_first), 32'(ch == 0));
    check_eq({tag, "_last"},  32'(out_last), 32'(ch == NUM_CH - 1));
    check_eq({tag, "_user"},  32'(out_user), 32'(user));
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_valid"},   32'(out_valid), 32'd0);
    check_eq({tag, "_data"},    32'(unsigned'(out_data)), 32'd0);
    check_eq({tag, "_chan"},    32'(out_chan), 32'd0);
    check_eq({tag, "_first"},   32'(out_first), 32'd0);
    check_eq({tag, "_last"},    32'(out_last), 32'd0);
    check_eq({tag, "_user"},    32'(out_user), 32'd0);
    check_eq({tag, "_locked"},  32'(locked), 32'd0);
    check_eq({tag, "_overrun"}, 32'(overrun_count), 32'd0);
    check_eq({tag, "_bad"},     32'(bad_count), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    tick(1);
  endtask

  initial begin
    logic seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_ready  = 1'b0;
    in_user   = 3'b000;
    in_audio  = '0;
    out_ready = 1'b1;
    tick(2);
    check_all_zero("reset");
    rst = 1'b0;
    tick(1);

    // Single frame, 1..8, out_ready high
    frame_start(1'b1, 24'h000001, 3'b101);
    tick(1);
    check_eq("t1_latency_not_yet", 32'(out_valid), 32'd0);
    tick(1);
    for (int i = 0; i < NUM_CH; i++) begin
      check_beat($sformatf("t1_ch%0d", i), i, 24'(i + 1), 3'b101);
      tick(1);
    end
    check_eq("t1_idle_after", 32'(out_valid), 32'd0);
    check_eq("t1_not_locked", 32'(locked), 32'd0);
    frame_end();
    tick(1);

    // Back-pressure: A held, B in shadow, C dropped
    out_ready = 1'b0;
    frame_start(1'b1, 24'h000100, 3'b001);
    tick(1);
    frame_end();
    tick(2);
    frame_start(1'b1, 24'h000200, 3'b110);
    tick(1);
    frame_end();
    tick(1);
    frame_start(1'b1, 24'h000300, 3'b011);
    tick(1);
    frame_end();
    check_eq("t2_overrun", 32'(overrun_count), 32'd1);
    tick(3);
    check_beat("t2_hold", 0, 24'h000100, 3'b001);
    check_eq("t2_locked", 32'(locked), 32'd1);
    out_ready = 1'b1;
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      if (i < NUM_CH) check_beat($sformatf("t2_a%0d", i), i, 24'(24'h100 + i), 3'b001);
      else check_beat($sformatf("t2_b%0d", i - NUM_CH), i - NUM_CH, 24'(24'h200 + i - NUM_CH), 3'b110);
      tick(1);
    end
    check_eq("t2_idle_after", 32'(out_valid), 32'd0);
    check_eq("t2_overrun_final", 32'(overrun_count), 32'd1);

    // Lock then timeout
    do_reset();
    frame_start(1'b1, 24'h000010, 3'b000);
    tick(1);
    check_eq("t3_lock_after_1", 32'(locked), 32'd0);
    frame_end();
    tick(10);
    frame_start(1'b1, 24'h000020, 3'b000);
    tick(1);
    check_eq("t3_lock_after_2", 32'(locked), 32'd1);
    frame_end();
    tick(4095);
    check_eq("t3_lock_at_4095", 32'(locked), 32'd1);
    tick(1);
    check_eq("t3_unlock_at_4096", 32'(locked), 32'd0);
    tick(5);
    check_eq("t3_stays_unlocked", 32'(locked), 32'd0);

    // Invalid frame while locked
    frame_start(1'b1, 24'h000030, 3'b000);
    tick(1);
    frame_end();
    tick(10);
    frame_start(1'b1, 24'h000040, 3'b000);
    tick(1);
    check_eq("t4_relocked", 32'(locked), 32'd1);
    frame_end();
    tick(12);
    frame_start(1'b0, 24'h000050, 3'b111);
    tick(1);
    check_eq("t4_bad_count", 32'(bad_count), 32'd1);
    check_eq("t4_unlocked", 32'(locked), 32'd0);
    frame_end();
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (out_valid) seen = 1'b1;
      tick(1);
    end
    check_eq("t4_no_beats", 32'(seen), 32'd0);
    frame_start(1'b1, 24'h000060, 3'b000);
    tick(1);
    check_eq("t4_lock_after_v1", 32'(locked), 32'd0);
    frame_end();
    tick(10);
    frame_start(1'b1, 24'h000070, 3'b000);
    tick(1);
    check_eq("t4_lock_after_v2", 32'(locked), 32'd1);
    frame_end();
    tick(12);

    // Shadow transfer coincides with a new capture
    frame_start(1'b1, 24'h000A00, 3'b001);
    tick(1);
    frame_end();
    tick(1);
    frame_start(1'b1, 24'h000B00, 3'b010);
    tick(1);
    frame_end();
    tick(6);
    check_eq("t5_p_ch7", 32'(out_chan), 32'd7);
    frame_start(1'b1, 24'h000C00, 3'b100);
    tick(1);
    frame_end();
    check_eq("t5_no_overrun", 32'(overrun_count), 32'd0);
    for (int i = 0; i < 2 * NUM_CH; i++) begin
      if (i < NUM_CH) check_beat($sformatf("t5_q%0d", i), i, 24'(24'hB00 + i), 3'b010);
      else check_beat($sformatf("t5_r%0d", i - NUM_CH), i - NUM_CH, 24'(24'hC00 + i - NUM_CH), 3'b100);
      tick(1);
    end
    check_eq("t5_idle_after", 32'(out_valid), 32'd0);

    // Reset mid-stream with in_ready held high
    frame_start(1'b1, 24'h000D00, 3'b111);
    tick(5);
    check_eq("t6_at_ch3", 32'(out_chan), 32'd3);
    rst = 1'b1;
    #1;
    check_all_zero("t6_rst");
    tick(1);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (out_valid) seen = 1'b1;
      tick(1);
    end
    check_eq("t6_no_capture_held", 32'(seen), 32'd0);
    frame_end();
    tick(1);
    frame_start(1'b1, 24'h000E00, 3'b010);
    tick(1);
    check_eq("t6_not_yet", 32'(out_valid), 32'd0);
    tick(1);
    check_beat("t6_recap", 0, 24'h000E00, 3'b010);
    frame_end();
    tick(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
